// File: rtl/obi_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : obi_axi_pkg
//  Description : AXI4 channel/bundle types for a 32-bit manager port, burst
//                and response encodings, and the AxSIZE helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package obi_axi_pkg;

    localparam logic [1:0] c_burst_incr  = 2'b01;
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_exokay = 2'b01;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } axi_32_aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic [0:0]  user;
    } axi_32_w_chan_t;

    typedef struct packed {
        logic [0:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } axi_32_b_chan_t;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } axi_32_ar_chan_t;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } axi_32_r_chan_t;

    typedef struct packed {
        axi_32_aw_chan_t aw;
        logic            aw_valid;
        axi_32_w_chan_t  w;
        logic            w_valid;
        logic            b_ready;
        axi_32_ar_chan_t ar;
        logic            ar_valid;
        logic            r_ready;
    } axi_32_req_t;

    typedef struct packed {
        logic           aw_ready;
        logic           ar_ready;
        logic           w_ready;
        logic           b_valid;
        axi_32_b_chan_t b;
        logic           r_valid;
        axi_32_r_chan_t r;
    } axi_32_resp_t;

    // AxSIZE for a full-width beat: log2 of the bus width in bytes.
    function automatic logic [2:0] axi_size(int dw);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == dw) s = 3'(i);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/obi_axi_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : obi_axi_bridge_if
//  Description : OBI address/response phase bundle between a core port
//                (master) and the OBI-to-AXI bridge (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface obi_axi_bridge_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface
`default_nettype wire

// File: rtl/obi_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : obi_axi_bridge
//  Description : OBI-to-AXI4 manager bridge. Single-beat transactions, up to
//                MAX_OUTSTANDING in flight, one direction at a time so OBI
//                responses stay in request order. AW and W are accepted
//                independently; responses pass through combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module obi_axi_bridge
    import obi_axi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = 1,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter type         axi_req_t       = axi_32_req_t,
    parameter type         axi_resp_t      = axi_32_resp_t
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    obi_axi_bridge_if.slave obi,
    output axi_req_t        axi_req_o,
    input  axi_resp_t       axi_resp_i
);

    localparam int unsigned              c_cnt_w   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_cnt_w-1:0]       c_max_out = c_cnt_w'(MAX_OUTSTANDING);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_dir;
    logic               r_aw_done;
    logic               r_w_done;

    logic w_allow;
    logic w_aw_valid;
    logic w_w_valid;
    logic w_ar_valid;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_wr_gnt;
    logic w_rd_gnt;
    logic w_gnt;
    logic w_rsp;
    logic w_unused;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_addr  = obi.addr[ADDR_WIDTH-1:0];
    assign w_wdata = obi.wdata[DATA_WIDTH-1:0];

    // Issue gate: room left, and direction only changes once the bridge is empty.
    assign w_allow    = (r_cnt < c_max_out) && ((r_cnt == '0) || (r_dir == obi.we));

    assign w_aw_valid = obi.req & obi.we & w_allow & ~r_aw_done;
    assign w_w_valid  = obi.req & obi.we & w_allow & ~r_w_done;
    assign w_ar_valid = obi.req & ~obi.we & w_allow;

    assign w_aw_fire  = w_aw_valid & axi_resp_i.aw_ready;
    assign w_w_fire   = w_w_valid & axi_resp_i.w_ready;

    // A write is granted once both AW and W have been taken, now or earlier.
    assign w_wr_gnt   = obi.req & obi.we & w_allow
                      & (w_aw_fire | r_aw_done) & (w_w_fire | r_w_done);
    assign w_rd_gnt   = w_ar_valid & axi_resp_i.ar_ready;
    assign w_gnt      = w_wr_gnt | w_rd_gnt;

    assign w_rsp      = axi_resp_i.r_valid | axi_resp_i.b_valid;

    // AXI request channels driven straight from the held OBI request.
    always_comb begin
        axi_req_o             = '0;
        axi_req_o.aw_valid    = w_aw_valid;
        axi_req_o.aw.id       = {ID_WIDTH{1'b0}};
        axi_req_o.aw.addr     = w_addr;
        axi_req_o.aw.len      = 8'd0;
        axi_req_o.aw.size     = axi_size(DATA_WIDTH);
        axi_req_o.aw.burst    = c_burst_incr;
        axi_req_o.w_valid     = w_w_valid;
        axi_req_o.w.data      = w_wdata;
        axi_req_o.w.strb      = obi.be;
        axi_req_o.w.last      = 1'b1;
        axi_req_o.ar_valid    = w_ar_valid;
        axi_req_o.ar.id       = {ID_WIDTH{1'b0}};
        axi_req_o.ar.addr     = w_addr;
        axi_req_o.ar.len      = 8'd0;
        axi_req_o.ar.size     = axi_size(DATA_WIDTH);
        axi_req_o.ar.burst    = c_burst_incr;
        axi_req_o.r_ready     = 1'b1;
        axi_req_o.b_ready     = 1'b1;
    end

    // OBI grant and zero-latency response path; B carries no data.
    always_comb begin
        obi.gnt    = w_gnt;
        obi.rvalid = w_rsp;
        obi.rdata  = axi_resp_i.r_valid ? axi_resp_i.r.data : '0;
        obi.err    = (axi_resp_i.r_valid & axi_resp_i.r.resp[1])
                   | (axi_resp_i.b_valid & axi_resp_i.b.resp[1]);
    end

    // Response fields the bridge does not need (IDs are always 0, single beat).
    assign w_unused = ^{axi_resp_i.r.id, axi_resp_i.r.resp[0], axi_resp_i.r.last,
                        axi_resp_i.r.user, axi_resp_i.b.id, axi_resp_i.b.resp[0],
                        axi_resp_i.b.user};

    // Outstanding counter: grant and response in one cycle cancel out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            case ({w_gnt, w_rsp})
                2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
                2'b01:   r_cnt <= r_cnt - c_cnt_w'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Direction of the transactions currently in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dir <= 1'b0;
        end else if (w_gnt) begin
            r_dir <= obi.we;
        end
    end

    // Remember AW/W acceptance until the write is granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_wr_gnt) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_fire) r_aw_done <= 1'b1;
            if (w_w_fire)  r_w_done  <= 1'b1;
        end
    end

    a_obi_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (obi.req && !obi.gnt) |=> $stable({obi.addr, obi.we, obi.be, obi.wdata}));

    a_no_rsp_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        w_rsp |-> (r_cnt != '0));

    a_r_last: assert property (@(posedge clk_i) disable iff (rst_i)
        axi_resp_i.r_valid |-> axi_resp_i.r.last);

endmodule
`default_nettype wire

// File: tb/tb_obi_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obi_axi_bridge
//  Description : Randomized bench for obi_axi_bridge: random OBI master,
//                random-latency AXI subordinate with its own memory, and a
//                transaction-level reference of the OBI-visible behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_axi_bridge;
    import obi_axi_pkg::*;

    localparam int unsigned MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obi_axi_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) obi_bus ();
    axi_32_req_t  axi_req;
    axi_32_resp_t axi_resp;

    obi_axi_bridge #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (32),
        .ID_WIDTH        (1),
        .MAX_OUTSTANDING (MAX_OUT),
        .axi_req_t       (axi_32_req_t),
        .axi_resp_t      (axi_32_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .obi        (obi_bus),
        .axi_req_o  (axi_req),
        .axi_resp_i (axi_resp)
    );

    typedef struct { logic [31:0] data; logic err; } exp_t;
    typedef struct { logic [31:0] d; logic [3:0] s; } wbeat_t;
    typedef struct { logic [31:0] d; logic [1:0] resp; } rbeat_t;

    int n_cmp = 0;
    int n_mis = 0;

    // reference (OBI-level) state
    logic [31:0] ref_mem [16];
    exp_t        exp_q [$];
    int          out_cnt;
    logic        out_dir;
    // OBI master state
    bit          have_req;
    logic        cur_we;
    logic [3:0]  cur_idx;
    logic [3:0]  cur_be;
    logic [31:0] cur_wdata;
    logic        aw_acc, w_acc;
    // AXI subordinate state
    logic [31:0] slv_mem [16];
    logic [3:0]  awq [$];
    wbeat_t      wq [$];
    rbeat_t      rq [$];
    logic [1:0]  bq [$];
    bit          drv_r, drv_b;
    // knobs
    bit          gen_en = 1'b1;
    int          force_dir = 0;
    bit          hold_resp = 1'b0;
    bit          hold_w = 1'b0;
    int          rdy_pct = 60;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] addr_of(logic [3:0] idx);
        return 32'h0000_1000 + 32'(idx) * 32'd4;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // subordinate's response choice per word: 13 SLVERR, 14 DECERR, 15 EXOKAY
    function automatic logic [1:0] slv_resp(logic [3:0] idx);
        case (idx)
            4'd13:   return 2'b10;
            4'd14:   return 2'b11;
            4'd15:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete(); awq.delete(); wq.delete(); rq.delete(); bq.delete();
        out_cnt = 0; out_dir = 1'b0; have_req = 1'b0; aw_acc = 1'b0; w_acc = 1'b0;
        drv_r = 1'b0; drv_b = 1'b0;
    endtask

    task automatic drive();
        if (gen_en && !have_req && $urandom_range(0, 99) < 60) begin
            have_req  = 1'b1;
            case (force_dir)
                1:       cur_we = 1'b0;
                2:       cur_we = 1'b1;
                default: cur_we = 1'($urandom_range(0, 1));
            endcase
            cur_idx   = 4'($urandom_range(0, 15));
            cur_be    = 4'($urandom_range(0, 15));
            cur_wdata = $urandom;
        end
        obi_bus.req   = have_req;
        obi_bus.we    = cur_we;
        obi_bus.be    = cur_be;
        obi_bus.addr  = addr_of(cur_idx);
        obi_bus.wdata = cur_wdata;

        axi_resp          = '0;
        axi_resp.aw_ready = ($urandom_range(0, 99) < rdy_pct);
        axi_resp.w_ready  = !hold_w && ($urandom_range(0, 99) < rdy_pct);
        axi_resp.ar_ready = ($urandom_range(0, 99) < rdy_pct);
        drv_r = !hold_resp && (rq.size() != 0) && ($urandom_range(0, 99) < 70);
        drv_b = !hold_resp && !drv_r && (bq.size() != 0) && ($urandom_range(0, 99) < 70);
        if (drv_r) begin
            axi_resp.r_valid = 1'b1;
            axi_resp.r.data  = rq[0].d;
            axi_resp.r.resp  = rq[0].resp;
            axi_resp.r.last  = 1'b1;
        end
        if (drv_b) begin
            axi_resp.b_valid = 1'b1;
            axi_resp.b.resp  = bq[0];
        end
    endtask

    task automatic sample();
        logic legal, exp_gnt, e_err;
        exp_t e;
        rbeat_t rb;
        wbeat_t wb;
        logic [3:0] ai;

        legal   = (out_cnt < int'(MAX_OUT)) && (out_cnt == 0 || out_dir == cur_we);
        exp_gnt = have_req && legal && (cur_we ? ((aw_acc || axi_resp.aw_ready) && (w_acc || axi_resp.w_ready))
                                               : axi_resp.ar_ready);
        check_eq("aw_valid", 32'(axi_req.aw_valid), 32'(have_req && cur_we && legal && !aw_acc));
        check_eq("w_valid",  32'(axi_req.w_valid),  32'(have_req && cur_we && legal && !w_acc));
        check_eq("ar_valid", 32'(axi_req.ar_valid), 32'(have_req && !cur_we && legal));
        check_eq("gnt",      32'(obi_bus.gnt),      32'(exp_gnt));
        check_eq("rvalid",   32'(obi_bus.rvalid),   32'(drv_r || drv_b));
        check_eq("rb_ready", 32'({axi_req.r_ready, axi_req.b_ready}), 32'd3);

        // responses, in request order
        if (drv_r || drv_b) begin
            check_eq("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("rdata", obi_bus.rdata, e.data);
                check_eq("err", 32'(obi_bus.err), 32'(e.err));
            end
            out_cnt--;
            if (drv_r) void'(rq.pop_front());
            else       void'(bq.pop_front());
        end

        // subordinate side handshakes
        if (axi_req.aw_valid && axi_resp.aw_ready) begin
            check_eq("aw_addr", axi_req.aw.addr, addr_of(cur_idx));
            check_eq("aw_attr", 32'({axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst}), 32'({8'd0, 3'd2, 2'b01}));
            check_eq("aw_zero", 32'({axi_req.aw.id, axi_req.aw.lock, axi_req.aw.cache, axi_req.aw.prot,
                                     axi_req.aw.qos, axi_req.aw.region, axi_req.aw.atop, axi_req.aw.user}), 32'd0);
            awq.push_back(axi_req.aw.addr[5:2]);
            aw_acc = 1'b1;
        end
        if (axi_req.w_valid && axi_resp.w_ready) begin
            check_eq("w_data", axi_req.w.data, cur_wdata);
            check_eq("w_strb_last", 32'({axi_req.w.strb, axi_req.w.last}), 32'({cur_be, 1'b1}));
            wb.d = axi_req.w.data; wb.s = axi_req.w.strb;
            wq.push_back(wb);
            w_acc = 1'b1;
        end
        if (axi_req.ar_valid && axi_resp.ar_ready) begin
            check_eq("ar_addr", axi_req.ar.addr, addr_of(cur_idx));
            check_eq("ar_attr", 32'({axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst, axi_req.ar.id}),
                     32'({8'd0, 3'd2, 2'b01, 1'b0}));
            ai = axi_req.ar.addr[5:2];
            rb.d = slv_mem[ai]; rb.resp = slv_resp(ai);
            rq.push_back(rb);
        end
        while (awq.size() != 0 && wq.size() != 0) begin
            ai = awq.pop_front();
            wb = wq.pop_front();
            slv_mem[ai] = merge(slv_mem[ai], wb.d, wb.s);
            bq.push_back(slv_resp(ai));
        end

        // reference model: an accepted OBI request owes one ordered response
        if (obi_bus.gnt) begin
            e_err = (cur_idx == 4'd13) || (cur_idx == 4'd14);
            if (cur_we) begin
                ref_mem[cur_idx] = merge(ref_mem[cur_idx], cur_wdata, cur_be);
                e.data = 32'd0;
            end else begin
                e.data = ref_mem[cur_idx];
            end
            e.err = e_err;
            exp_q.push_back(e);
            out_cnt++;
            out_dir  = cur_we;
            have_req = 1'b0;
            aw_acc   = 1'b0;
            w_acc    = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic drain();
        int n;
        n = 0;
        gen_en = 1'b0;
        while ((have_req || exp_q.size() != 0) && n < 500) begin
            cycle();
            n++;
        end
        check_eq("drain_done", 32'(n < 500), 32'd1);
        gen_en = 1'b1;
    endtask

    task automatic check_idle_state(input string tag);
        check_eq({tag, "_cnt"},  32'(dut.r_cnt), 32'd0);
        check_eq({tag, "_dir"},  32'(dut.r_dir), 32'd0);
        check_eq({tag, "_done"}, 32'({dut.r_aw_done, dut.r_w_done}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            slv_mem[i] = v;
        end
        model_reset();
        cur_we = 1'b0; cur_idx = 4'd0; cur_be = 4'd0; cur_wdata = 32'd0;
        obi_bus.req = 1'b0; obi_bus.we = 1'b0; obi_bus.be = '0;
        obi_bus.addr = '0; obi_bus.wdata = '0;
        axi_resp = '0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_state("reset");
        check_eq("reset_outs", 32'({obi_bus.gnt, obi_bus.rvalid, axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid}), 32'd0);
        rst = 1'b0;

        // mixed random traffic
        repeat (2000) cycle();
        drain();

        // fill with reads while responses are withheld, then release
        force_dir = 1; hold_resp = 1'b1; rdy_pct = 100;
        repeat (12) cycle();
        check_eq("full_cnt", 32'(dut.r_cnt), MAX_OUT);
        check_eq("full_stall", 32'({obi_bus.gnt, axi_req.ar_valid}), 32'd0);
        hold_resp = 1'b0; rdy_pct = 60;
        repeat (200) cycle();
        drain();

        // two writes outstanding plus a half-accepted third, then async reset
        force_dir = 2; hold_resp = 1'b1; rdy_pct = 100;
        n = 0;
        while (out_cnt < 2 && n < 50) begin cycle(); n++; end
        check_eq("fill_writes", 32'(out_cnt), 32'd2);
        hold_w = 1'b1;
        n = 0;
        while (!aw_acc && n < 50) begin cycle(); n++; end
        check_eq("aw_only_accepted", 32'(aw_acc), 32'd1);
        @(posedge clk); #1;
        check_eq("pre_rst_state", 32'({dut.r_cnt, dut.r_dir, dut.r_aw_done, dut.r_w_done}),
                 32'({3'd2, 1'b1, 1'b1, 1'b0}));
        rst = 1'b1;
        obi_bus.req = 1'b0;
        axi_resp = '0;
        model_reset();
        #1;
        check_idle_state("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        hold_w = 1'b0; hold_resp = 1'b0; force_dir = 0; rdy_pct = 60;

        repeat (800) cycle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
